// File: rtl/scan_piso_tx.sv
// scan_piso_tx: parallel-in/serial-out transmitter for the scan encryption link.
// Accepts one DATA_W-bit word over valid/ready and shifts it out MSB-first,
// one bit per shift_en cycle. Bit order matches the 128-bit SIPO capture block.
// Optional feature: define SCAN_PISO_PARITY_EN to append an even-parity bit
// after the LSB (frame becomes DATA_W+1 bits).
module scan_piso_tx #(
    parameter int DATA_W = 128
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    input  logic              i_shift_en,
    input  logic              i_abort,
    output logic              o_serial_out,
    output logic              o_serial_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

`ifdef SCAN_PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd3
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_shreg;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               w_load;
    logic               w_shift;
    logic               w_clear;
    logic               w_last_bit;

`ifdef SCAN_PISO_PARITY_EN
    logic               r_parity;

    // Even parity over the whole word; the parity bit makes the frame's 1-count even.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        even_parity = ^word;
    endfunction
`endif

    assign w_last_bit = (r_bit_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and datapath control strobes; abort outranks shift_en.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_data_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (i_abort) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (i_shift_en) begin
                    w_shift = 1'b1;
                    if (w_last_bit) begin
`ifdef SCAN_PISO_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
`ifdef SCAN_PISO_PARITY_EN
            ST_PARITY: begin
                if (i_abort) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (i_shift_en) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
`endif
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register and bit counter; the counter parks on the last index rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_shreg   <= i_data_in;
            r_bit_cnt <= '0;
        end else if (w_clear) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_shift) begin
            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
            if (!w_last_bit) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end else begin
            r_shreg   <= r_shreg;
            r_bit_cnt <= r_bit_cnt;
        end
    end

`ifdef SCAN_PISO_PARITY_EN
    // Parity bit captured with the word at the accept edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= even_parity(i_data_in);
        end else begin
            r_parity <= r_parity;
        end
    end
`endif

    // Output decode straight from registered state; serial_out is forced low outside a frame.
    always_comb begin
        o_data_ready   = 1'b0;
        o_serial_out   = 1'b0;
        o_serial_valid = 1'b0;
        o_busy         = 1'b0;
        o_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_data_ready = 1'b1;
            end
            ST_SHIFT: begin
                o_serial_out   = r_shreg[DATA_W-1];
                o_serial_valid = 1'b1;
                o_busy         = 1'b1;
            end
`ifdef SCAN_PISO_PARITY_EN
            ST_PARITY: begin
                o_serial_out   = r_parity;
                o_serial_valid = 1'b1;
                o_busy         = 1'b1;
            end
`endif
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_data_ready = 1'b0;
            end
        endcase
    end

endmodule
